threebitcounter_ctrl: RTL and testbench

- Round-robin command scheduler that shares one three-bit counter between NREQ requesters.
- Each requester issues a load or increment command over a valid/ready handshake. The block serialises these commands onto the counter's ld/inc/data_in controls.
- Increments at the counter's maximum value are never issued. They are completed with an error flag instead, so the counter firewall's "no increment at 3'h7" check can never fire.

---
 rtl/threebitcounter_ctrl.sv | 133 +++++++++++++
 tb/tb_threebitcounter_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/threebitcounter_ctrl.sv
// Round-robin scheduler that serialises load/increment commands from NREQ
// requesters onto a shared saturating counter's ld/inc/data_in controls.
module threebitcounter_ctrl #(
   parameter int NREQ  = 2,
   parameter int WIDTH = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ-1:0]         req_op,
   input  logic [NREQ*WIDTH-1:0]   req_data,
   output logic [NREQ-1:0]         req_ready,
   output logic [NREQ-1:0]         req_err,
   output logic                    ld,
   output logic                    inc,
   output logic [WIDTH-1:0]        data_in,
   input  logic [WIDTH-1:0]        data_out,
   output logic                    busy,
   output logic [1:0]              dbg_state
);

   // Handshake: a requester raises req_valid with op/data and holds all three
   // stable until its one-cycle req_ready pulse; the command completes on that
   // cycle's rising edge. req_err qualifies req_ready (rejected increment).

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [WIDTH-1:0] MAXV = {WIDTH{1'b1}};

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ISSUE  = 2'd1,
      S_SETTLE = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [IW-1:0]    rr_q, rr_d;
   logic [IW-1:0]    grant_q, grant_d;
   logic             op_q, op_d;
   logic [WIDTH-1:0] data_q, data_d;

   logic             any_valid;
   logic [IW-1:0]    pick;

   // Search downward in offset so the requester closest to the pointer wins.
   always_comb begin
      int idx;
      idx       = 0;
      any_valid = 1'b0;
      pick      = rr_q;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = (int'(rr_q) + k) % NREQ;
         if (req_valid[idx]) begin
            any_valid = 1'b1;
            pick      = IW'(idx);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         rr_q    <= '0;
         grant_q <= '0;
         op_q    <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         grant_q <= grant_d;
         op_q    <= op_d;
         data_q  <= data_d;
      end
   end

   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      grant_d = grant_q;
      op_d    = op_q;
      data_d  = data_q;
      case (state_q)
         S_IDLE: begin
            if (any_valid) begin
               grant_d = pick;
               op_d    = req_op[pick];
               data_d  = req_data[int'(pick)*WIDTH +: WIDTH];
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (grant_q == IW'(NREQ - 1)) begin
               rr_d = '0;
            end else begin
               rr_d = grant_q + IW'(1);
            end
            state_d = S_SETTLE;
         end
         S_SETTLE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // An increment at MAXV is completed with an error instead of being issued.
   always_comb begin
      ld        = 1'b0;
      inc       = 1'b0;
      data_in   = '0;
      req_ready = '0;
      req_err   = '0;
      busy      = (state_q != S_IDLE);
      dbg_state = state_q;
      if (state_q == S_ISSUE) begin
         for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = (grant_q == IW'(i));
         end
         if (op_q) begin
            ld      = 1'b1;
            data_in = data_q;
         end else if (data_out != MAXV) begin
            inc = 1'b1;
         end else begin
            for (int i = 0; i < NREQ; i++) begin
               req_err[i] = (grant_q == IW'(i));
            end
         end
      end
   end

endmodule

// File: tb/tb_threebitcounter_ctrl.sv
// Bench for threebitcounter_ctrl: environment counter, queued requesters,
// command-level reference model with per-cycle compare, directed and random runs.
module tb_threebitcounter_ctrl;

   localparam int NREQ = 2;
   localparam int W    = 3;
   localparam int MAXV = (1 << W) - 1;

   typedef struct packed {
      logic         op;
      logic [W-1:0] d;
   } cmd_t;

   logic              clk;
   logic              rst;
   logic              env_clr;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_op;
   logic [NREQ*W-1:0] req_data;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ-1:0]   req_err;
   logic              ld;
   logic              inc;
   logic [W-1:0]      data_in;
   logic [W-1:0]      data_out;
   logic              busy;
   logic [1:0]        dbg_state;

   logic [W-1:0]      cnt;
   int                fw_errs;
   int                cyc;
   int                checks;
   int                errors;

   cmd_t              cmd_q[NREQ][$];
   logic [NREQ-1:0]   ready_seen;
   logic [W-1:0]      exp_q[$];

   // reference model: command in flight and cycles left in it
   int                m_left;
   int                m_g;
   int                m_rr;
   int                m_cnt;
   int                m_dat;
   bit                m_op;
   int                mw;

   int ev_gnt[16];
   int ev_ld[16];
   int ev_inc[16];
   int ev_err[16];
   int ev_din[16];
   int ev_cyc[16];
   int ev_dout[16];

   threebitcounter_ctrl #(.NREQ(NREQ), .WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_op    (req_op),
      .req_data  (req_data),
      .req_ready (req_ready),
      .req_err   (req_err),
      .ld        (ld),
      .inc       (inc),
      .data_in   (data_in),
      .data_out  (data_out),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign data_out = cnt;

   // the shared counter plus its firewall
   always @(posedge clk or posedge env_clr) begin
      if (env_clr) begin
         cnt     <= '0;
         fw_errs <= 0;
         cyc     <= 0;
      end else begin
         cyc <= cyc + 1;
         if ((inc && int'(cnt) == MAXV) || (ld && inc)) fw_errs <= fw_errs + 1;
         if (ld) cnt <= data_in;
         else if (inc) cnt <= cnt + 1'b1;
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(posedge clk or negedge rst or posedge env_clr) begin
      if (env_clr) begin
         m_left = 0;
         m_rr   = 0;
         m_cnt  = 0;
         exp_q.delete();
      end else if (!rst) begin
         m_left = 0;
         m_rr   = 0;
         exp_q.delete();
      end else if (m_left == 0) begin
         for (int k = 0; k < NREQ; k++) begin
            mw = (m_rr + k) % NREQ;
            if (req_valid[mw] && m_left == 0) begin
               m_g    = mw;
               m_op   = req_op[mw];
               m_dat  = int'(req_data[mw*W +: W]);
               m_left = 2;
            end
         end
      end else begin
         if (m_left == 2) begin
            if (m_op) m_cnt = m_dat;
            else if (m_cnt < MAXV) m_cnt = m_cnt + 1;
            m_rr = (m_g + 1) % NREQ;
            exp_q.push_back(W'(m_cnt));
         end
         m_left = m_left - 1;
      end
   end

   always @(negedge clk) begin
      bit           issue;
      logic [NREQ-1:0] e_rdy;
      logic [NREQ-1:0] e_err;
      ready_seen = req_ready;
      issue = (m_left == 2);
      e_rdy = '0;
      e_err = '0;
      if (issue) begin
         e_rdy[m_g] = 1'b1;
         if (!m_op && m_cnt == MAXV) e_err[m_g] = 1'b1;
      end
      chk("busy",      busy,      m_left != 0);
      chk("ld",        ld,        issue && m_op);
      chk("inc",       inc,       issue && !m_op && m_cnt < MAXV);
      chk("data_in",   data_in,   (issue && m_op) ? m_dat : 0);
      chk("req_ready", req_ready, e_rdy);
      chk("req_err",   req_err,   e_err);
      chk("data_out",  data_out,  m_cnt);
      if (m_left == 1) begin
         if (exp_q.size() == 0) chk("scoreboard_entry", 0, 1);
         else chk("settled_value", data_out, int'(exp_q.pop_front()));
      end
   end

   // requester driver: completes on the edge after a seen ready pulse
   initial begin
      logic [NREQ-1:0] done_v;
      cmd_t            c;
      req_valid = '0;
      req_op    = '0;
      req_data  = '0;
      forever begin
         @(posedge clk);
         done_v = ready_seen & {NREQ{rst}};
         #1;
         for (int i = 0; i < NREQ; i++) begin
            if (done_v[i]) req_valid[i] = 1'b0;
            if (!req_valid[i] && cmd_q[i].size() > 0) begin
               c                 = cmd_q[i].pop_front();
               req_valid[i]      = 1'b1;
               req_op[i]         = c.op;
               req_data[i*W +: W] = c.d;
            end
         end
      end
   end

   task automatic push(input int r, input bit op, input int d);
      cmd_t c;
      c.op = op;
      c.d  = W'(d);
      cmd_q[r].push_back(c);
   endtask

   task automatic collect(input int n);
      int got;
      int t;
      int pend;
      got  = 0;
      t    = 0;
      pend = -1;
      while (got < n && t < 20 * n) begin
         @(negedge clk);
         t++;
         if (pend >= 0) begin
            ev_dout[pend] = int'(data_out);
            pend = -1;
         end
         if (|req_ready) begin
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) ev_gnt[got] = i;
            ev_ld[got]  = ld;
            ev_inc[got] = inc;
            ev_err[got] = int'(req_err);
            ev_din[got] = int'(data_in);
            ev_cyc[got] = cyc;
            pend = got;
            got++;
         end
      end
      if (pend >= 0) begin
         @(negedge clk);
         ev_dout[pend] = int'(data_out);
      end
      chk("collect_events", got, n);
   endtask

   initial begin
      int c0;
      int p;
      int t;
      checks     = 0;
      errors     = 0;
      ready_seen = '0;
      rst        = 1'b0;
      env_clr    = 1'b1;
      #7 env_clr = 1'b0;

      repeat (3) @(negedge clk);
      chk("reset_ld", ld, 0);
      chk("reset_inc", inc, 0);
      chk("reset_busy", busy, 0);
      chk("reset_ready", req_ready, 0);
      chk("reset_data_in", data_in, 0);
      @(posedge clk);
      #1 rst = 1'b1;

      // reset during ISSUE
      push(0, 1'b1, 5);
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!ld && t < 10);
      chk("rstA_ld_seen", ld, 1);
      chk("rstA_data_in", data_in, 5);
      #2 rst = 1'b0;
      #1;
      chk("rstA_ld_drop", ld, 0);
      chk("rstA_ready_drop", req_ready, 0);
      chk("rstA_busy_drop", busy, 0);
      @(negedge clk);
      chk("rstA_no_update", data_out, 0);
      @(posedge clk);
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rstA_reissue_ld", ld, 1);
      chk("rstA_reissue_data", data_in, 5);
      @(negedge clk);
      chk("rstA_data_out", data_out, 5);
      repeat (3) @(negedge clk);

      // load then increment on one requester
      push(0, 1'b1, 3);
      collect(1);
      chk("B_ld", ev_ld[0], 1);
      chk("B_din", ev_din[0], 3);
      chk("B_err0", ev_err[0], 0);
      chk("B_dout3", ev_dout[0], 3);
      c0 = ev_cyc[0];
      repeat (4) @(negedge clk);
      push(0, 1'b0, 0);
      collect(1);
      chk("B_inc", ev_inc[0], 1);
      chk("B_err1", ev_err[0], 0);
      chk("B_dout4", ev_dout[0], 4);
      chk("B_spacing_ge6", (ev_cyc[0] - c0) >= 6, 1);

      // round robin from pointer 0
      push(1, 1'b1, 0);
      collect(1);
      chk("C_dout0", ev_dout[0], 0);
      repeat (2) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         push(0, 1'b0, 0);
         push(1, 1'b0, 0);
      end
      collect(4);
      for (int k = 0; k < 4; k++) chk("C_grant_order", ev_gnt[k], k % 2);
      for (int k = 1; k < 4; k++) chk("C_spacing", ev_cyc[k] - ev_cyc[k-1], 3);
      chk("C_dout_final", ev_dout[3], 4);
      repeat (2) @(negedge clk);

      // saturation
      push(0, 1'b1, 6);
      push(0, 1'b0, 0);
      push(0, 1'b0, 0);
      collect(3);
      chk("D_ld", ev_ld[0], 1);
      chk("D_din", ev_din[0], 6);
      chk("D_inc1", ev_inc[1], 1);
      chk("D_dout7", ev_dout[1], 7);
      chk("D_inc2_blocked", ev_inc[2], 0);
      chk("D_err2", ev_err[2], 1);
      chk("D_dout_hold", ev_dout[2], 7);
      chk("D_firewall", fw_errs, 0);
      repeat (2) @(negedge clk);

      // recovery after saturation
      push(1, 1'b1, 2);
      push(1, 1'b0, 0);
      collect(2);
      chk("E_dout2", ev_dout[0], 2);
      chk("E_dout3", ev_dout[1], 3);
      chk("E_err", ev_err[0] | ev_err[1], 0);
      repeat (2) @(negedge clk);

      // pointer skip: only req1 valid with pointer at 0
      p = cyc;
      push(1, 1'b0, 0);
      collect(1);
      chk("F_grant", ev_gnt[0], 1);
      chk("F_no_idle_slot", ev_cyc[0], p + 2);
      chk("F_dout4", ev_dout[0], 4);
      repeat (2) @(negedge clk);
      push(0, 1'b0, 0);
      push(1, 1'b0, 0);
      collect(2);
      chk("F_ptr_wrap_first", ev_gnt[0], 0);
      chk("F_ptr_wrap_second", ev_gnt[1], 1);

      // randomized traffic with occasional resets
      for (int n = 0; n < 1500; n++) begin
         @(negedge clk);
         if ($urandom_range(0, 2) == 0) begin
            p = $urandom_range(0, NREQ - 1);
            if (cmd_q[p].size() < 3)
               push(p, ($urandom_range(0, 3) == 0), $urandom_range(0, MAXV));
         end
         if ($urandom_range(0, 199) == 0) begin
            #2 rst = 1'b0;
            @(posedge clk);
            #1 rst = 1'b1;
         end
      end
      t = 0;
      while ((cmd_q[0].size() + cmd_q[1].size() != 0 || req_valid != '0 || busy) && t < 300) begin
         @(negedge clk);
         t++;
      end
      chk("drain_done", t < 300, 1);
      chk("firewall_total", fw_errs, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
